// File: rtl/fl_fifo_input_arbiter.sv
// Frame-granular arbiter sharing one FrameLink FIFO write port between INPUTS sources.
// Optional build macro FL_ARB_PRIORITY_EN: strict lowest-index priority instead of round-robin.
module fl_fifo_input_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int DREM_WIDTH = 3,
  parameter int INPUTS     = 4
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [INPUTS*DATA_WIDTH-1:0] RX_DATA,
  input  logic [INPUTS*DREM_WIDTH-1:0] RX_DREM,
  input  logic [INPUTS-1:0]            RX_SOF_N,
  input  logic [INPUTS-1:0]            RX_EOF_N,
  input  logic [INPUTS-1:0]            RX_SOP_N,
  input  logic [INPUTS-1:0]            RX_EOP_N,
  input  logic [INPUTS-1:0]            RX_SRC_RDY_N,
  output logic [INPUTS-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]        TX_DATA,
  output logic [DREM_WIDTH-1:0]        TX_DREM,
  output logic                         TX_SOF_N,
  output logic                         TX_EOF_N,
  output logic                         TX_SOP_N,
  output logic                         TX_EOP_N,
  output logic                         TX_SRC_RDY_N,
  input  logic                         TX_DST_RDY_N,
  output logic [INPUTS-1:0]            GRANT,
  output logic                         FRAME_ERR,
  output logic                         STATE_DBG
);

  localparam int IDX_W = $clog2(INPUTS);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [INPUTS-1:0] grant_q, grant_d;
  logic              first_q, first_d;
  logic              frame_err_q, frame_err_d;
  logic [INPUTS-1:0] req;
  logic              req_any;
  logic [IDX_W-1:0]  pick;
  logic              xfer;
  logic              sel_src, sel_sof, sel_eof, sel_sop, sel_eop;

  assign req     = ~RX_SRC_RDY_N;
  assign req_any = |req;

`ifdef FL_ARB_PRIORITY_EN
  // Descending scan so the lowest requesting index is the final assignment.
  always_comb begin
    pick = '0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      if (req[i]) pick = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest after last_q so the nearest requester wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = INPUTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % INPUTS);
      if (req[cand]) pick = cand;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q <= IDX_W'(INPUTS - 1);
    end else if (state_q == IDLE && req_any) begin
      last_q <= pick;
    end
  end
`endif

  // Pure one-hot mux from the registered grant; grant_q == 0 yields idle values.
  always_comb begin
    TX_DATA = '0;
    TX_DREM = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (grant_q[i]) begin
        TX_DATA = TX_DATA | RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        TX_DREM = TX_DREM | RX_DREM[i*DREM_WIDTH +: DREM_WIDTH];
      end
    end
  end

  assign sel_src = |(grant_q & ~RX_SRC_RDY_N);
  assign sel_sof = |(grant_q & ~RX_SOF_N);
  assign sel_eof = |(grant_q & ~RX_EOF_N);
  assign sel_sop = |(grant_q & ~RX_SOP_N);
  assign sel_eop = |(grant_q & ~RX_EOP_N);

  assign TX_SRC_RDY_N = ~sel_src;
  assign TX_SOF_N     = ~sel_sof;
  assign TX_EOF_N     = ~sel_eof;
  assign TX_SOP_N     = ~sel_sop;
  assign TX_EOP_N     = ~sel_eop;

  // Handshake: a word moves on a rising edge where TX_SRC_RDY_N=0 and TX_DST_RDY_N=0;
  // only the granted source sees the FIFO's ready, every other source sees not-ready.
  assign RX_DST_RDY_N = ~(grant_q & {INPUTS{~TX_DST_RDY_N}});
  assign xfer         = sel_src & ~TX_DST_RDY_N;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    first_d     = first_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant_d = INPUTS'(1) << pick;
          first_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          first_d     = 1'b0;
          frame_err_d = first_q & TX_SOF_N;
          if (!TX_EOF_N) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      first_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign GRANT     = grant_q;
  assign FRAME_ERR = frame_err_q;
  assign STATE_DBG = (state_q == LOCK);

endmodule

// File: tb/tb_fl_fifo_input_arbiter.sv
// Bench for fl_fifo_input_arbiter: per-source frame queues, a cycle model of the arbiter
// contract, and scenario tasks; honours FL_ARB_PRIORITY_EN for the expected grant order.
module tb_fl_fifo_input_arbiter;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int N  = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] drem;
    logic          sof;
    logic          eof;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*DW-1:0] rx_data;
  logic [N*RW-1:0] rx_drem;
  logic [N-1:0]  rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n, rx_dst_rdy_n;
  logic [DW-1:0] tx_data;
  logic [RW-1:0] tx_drem;
  logic          tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n, tx_dst_rdy_n;
  logic [N-1:0]  grant;
  logic          frame_err, state_dbg;

  fl_fifo_input_arbiter #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .INPUTS(N)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .RX_DATA(rx_data), .RX_DREM(rx_drem),
    .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
    .RX_SRC_RDY_N(rx_src_rdy_n), .RX_DST_RDY_N(rx_dst_rdy_n),
    .TX_DATA(tx_data), .TX_DREM(tx_drem),
    .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n), .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
    .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(tx_dst_rdy_n),
    .GRANT(grant), .FRAME_ERR(frame_err), .STATE_DBG(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  word_t src_q[N][$];
  int    m_gnt;
  int    m_last;
  bit    m_first;
  bit    m_err;
  int    grant_log[$];
  int    xfer_cnt;
  int    err_seen;
  int    src_stall_pct;
  int    dst_stall_pct;
  int    dst_block;
  logic [RW-1:0] obs_drem;
  logic [N-1:0]  cur_valid;

  task automatic model_reset();
    for (int i = 0; i < N; i++) src_q[i].delete();
    m_gnt = -1;
    m_last = N - 1;
    m_first = 1'b0;
    m_err = 1'b0;
    grant_log.delete();
    xfer_cnt = 0;
    err_seen = 0;
    dst_block = 0;
    obs_drem = '0;
  endtask

  task automatic add_frame(input int s, input int len, input bit bad_sof, input logic [RW-1:0] drem);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.data = {$urandom, $urandom};
      w.drem = (k == len - 1) ? drem : 3'd7;
      w.sof  = (k == 0) && !bad_sof;
      w.eof  = (k == len - 1);
      src_q[s].push_back(w);
    end
  endtask

  // driver
  task automatic drive_inputs();
    word_t h;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        cur_valid[i] = (int'($urandom_range(99)) >= src_stall_pct);
        rx_data[i*DW +: DW] = h.data;
        rx_drem[i*RW +: RW] = h.drem;
        rx_sof_n[i] = ~h.sof;
        rx_eof_n[i] = ~h.eof;
        rx_sop_n[i] = ~h.sof;
        rx_eop_n[i] = ~h.eof;
      end else begin
        cur_valid[i] = 1'b0;
        rx_data[i*DW +: DW] = '0;
        rx_drem[i*RW +: RW] = '0;
        rx_sof_n[i] = 1'b1;
        rx_eof_n[i] = 1'b1;
        rx_sop_n[i] = 1'b1;
        rx_eop_n[i] = 1'b1;
      end
      rx_src_rdy_n[i] = ~cur_valid[i];
    end
    if (dst_block > 0) begin
      tx_dst_rdy_n = 1'b1;
      dst_block--;
    end else begin
      tx_dst_rdy_n = (int'($urandom_range(99)) < dst_stall_pct);
    end
  endtask

  // One clock: drive after the falling edge, check, then advance the model past the next rising edge.
  task automatic cycle();
    logic [N-1:0]  exp_gnt, exp_dst;
    logic          exp_src;
    logic [DW-1:0] exp_data;
    logic [RW-1:0] exp_drem;
    logic [3:0]    exp_fr, got_fr;
    bit            nerr;
    word_t         w;
    int            g, p;
    @(negedge clk);
    drive_inputs();
    #1;
    g = m_gnt;
    if (g < 0) begin
      exp_gnt = '0; exp_src = 1'b1; exp_data = '0; exp_drem = '0; exp_fr = 4'hF; exp_dst = '1;
    end else begin
      exp_gnt = '0;
      exp_gnt[g] = 1'b1;
      exp_src  = rx_src_rdy_n[g];
      exp_data = rx_data[g*DW +: DW];
      exp_drem = rx_drem[g*RW +: RW];
      exp_fr   = {rx_sof_n[g], rx_eof_n[g], rx_sop_n[g], rx_eop_n[g]};
      exp_dst  = '1;
      exp_dst[g] = tx_dst_rdy_n;
    end
    got_fr = {tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};
    total++; if (grant !== exp_gnt) begin bad++; $display("FAIL grant t=%0t got=%b want=%b", $time, grant, exp_gnt); end
    total++; if (state_dbg !== (g >= 0)) begin bad++; $display("FAIL state_dbg t=%0t got=%b want=%b", $time, state_dbg, (g >= 0)); end
    total++; if (frame_err !== m_err) begin bad++; $display("FAIL frame_err t=%0t got=%b want=%b", $time, frame_err, m_err); end
    total++; if (tx_src_rdy_n !== exp_src) begin bad++; $display("FAIL tx_src_rdy_n t=%0t got=%b want=%b", $time, tx_src_rdy_n, exp_src); end
    total++; if (tx_data !== exp_data) begin bad++; $display("FAIL tx_data t=%0t got=%h want=%h", $time, tx_data, exp_data); end
    total++; if (tx_drem !== exp_drem) begin bad++; $display("FAIL tx_drem t=%0t got=%0d want=%0d", $time, tx_drem, exp_drem); end
    total++; if (got_fr !== exp_fr) begin bad++; $display("FAIL tx_framing t=%0t got=%b want=%b", $time, got_fr, exp_fr); end
    total++; if (rx_dst_rdy_n !== exp_dst) begin bad++; $display("FAIL rx_dst_rdy_n t=%0t got=%b want=%b", $time, rx_dst_rdy_n, exp_dst); end
    if (frame_err === 1'b1) err_seen++;

    nerr = 1'b0;
    if (g < 0) begin
      if (|cur_valid) begin
`ifdef FL_ARB_PRIORITY_EN
        p = 0;
        while (!cur_valid[p]) p++;
`else
        p = m_last;
        do p = (p + 1) % N; while (!cur_valid[p]);
        m_last = p;
`endif
        m_gnt = p;
        m_first = 1'b1;
        grant_log.push_back(p);
      end
    end else if (cur_valid[g] && !tx_dst_rdy_n) begin
      w = src_q[g].pop_front();
      xfer_cnt++;
      obs_drem = tx_drem;
      if (m_first && !w.sof) nerr = 1'b1;
      m_first = 1'b0;
      if (w.eof) m_gnt = -1;
    end
    m_err = nerr;
  endtask

  function automatic bit busy();
    bit b = (m_gnt >= 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_idle(input int budget, input string name);
    int n = 0;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (busy()) begin bad++; $display("FAIL %s_timeout cycles=%0d want idle within %0d", name, n, budget); end
    repeat (2) cycle();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    src_stall_pct = 0;
    dst_stall_pct = 0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    src_stall_pct = 0;
    dst_stall_pct = 0;
    add_frame(0, 2, 1'b0, 3'd1);
    drive_inputs();
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (tx_src_rdy_n !== 1'b1) begin bad++; $display("FAIL reset_tx_src_rdy_n got=%b want=1", tx_src_rdy_n); end
    total++; if ({tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n} !== 4'hF) begin bad++; $display("FAIL reset_framing got=%b want=1111", {tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n}); end
    total++; if (tx_data !== '0 || tx_drem !== '0) begin bad++; $display("FAIL reset_data got=%h/%0d want=0/0", tx_data, tx_drem); end
    total++; if (rx_dst_rdy_n !== 4'hF) begin bad++; $display("FAIL reset_rx_dst_rdy_n got=%b want=1111", rx_dst_rdy_n); end
    model_reset();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_sources();
    reset_dut();
    add_frame(0, 3, 1'b0, 3'd2);
    add_frame(2, 3, 1'b0, 3'd4);
    run_until_idle(50, "two_sources");
    total++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
      bad++; $display("FAIL two_sources_order got_n=%0d want 0 then 2", grant_log.size());
    end
    total++; if (xfer_cnt != 6) begin bad++; $display("FAIL two_sources_xfers got=%0d want=6", xfer_cnt); end
  endtask

  task automatic test_round_robin();
    int exp_order[8];
`ifdef FL_ARB_PRIORITY_EN
    exp_order = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) add_frame(i, 1, 1'b0, 3'(i));
    run_until_idle(100, "round_robin");
    total++; if (grant_log.size() != 8) begin bad++; $display("FAIL rr_count got=%0d want=8", grant_log.size()); end
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      total++;
      if (grant_log[k] != exp_order[k]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, grant_log[k], exp_order[k]); end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    reset_dut();
    add_frame(0, 5, 1'b0, 3'd6);
    add_frame(1, 2, 1'b0, 3'd0);
    while (xfer_cnt < 2 && n < 20) begin cycle(); n++; end
    dst_block = 4;
    run_until_idle(60, "stall");
    total++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
      bad++; $display("FAIL stall_order got_n=%0d want 0 then 1", grant_log.size());
    end
    total++; if (xfer_cnt != 7) begin bad++; $display("FAIL stall_xfers got=%0d want=7", xfer_cnt); end
  endtask

  task automatic test_frame_err();
    reset_dut();
    add_frame(3, 3, 1'b1, 3'd5);
    run_until_idle(40, "frame_err");
    total++; if (err_seen != 1) begin bad++; $display("FAIL frame_err_pulses got=%0d want=1", err_seen); end
    total++; if (xfer_cnt != 3) begin bad++; $display("FAIL frame_err_xfers got=%0d want=3", xfer_cnt); end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    reset_dut();
    add_frame(1, 4, 1'b0, 3'd3);
    while (xfer_cnt < 1 && n < 20) begin cycle(); n++; end
    @(negedge clk);
    drive_inputs();
    #1;
    total++; if (tx_src_rdy_n !== 1'b0 || grant !== 4'b0010) begin
      bad++; $display("FAIL mid_reset_pre got=%b/%b want=0/0010", tx_src_rdy_n, grant);
    end
    rst_n = 1'b0;
    #1;
    total++; if (tx_src_rdy_n !== 1'b1) begin bad++; $display("FAIL mid_reset_src got=%b want=1", tx_src_rdy_n); end
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_reset_grant got=%b want=0000", grant); end
    total++; if (rx_dst_rdy_n !== 4'hF) begin bad++; $display("FAIL mid_reset_dst got=%b want=1111", rx_dst_rdy_n); end
    model_reset();
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    add_frame(0, 2, 1'b0, 3'd1);
    add_frame(1, 2, 1'b0, 3'd2);
    run_until_idle(40, "mid_reset");
    total++; if (grant_log.size() < 1 || grant_log[0] != 0) begin bad++; $display("FAIL mid_reset_first_grant want=0"); end
  endtask

  task automatic test_single_word();
    reset_dut();
    add_frame(2, 1, 1'b0, 3'd5);
    run_until_idle(20, "single_word");
    total++; if (xfer_cnt != 1) begin bad++; $display("FAIL single_xfers got=%0d want=1", xfer_cnt); end
    total++; if (obs_drem !== 3'd5) begin bad++; $display("FAIL single_drem got=%0d want=5", obs_drem); end
  endtask

  task automatic test_random();
    reset_dut();
    src_stall_pct = 20;
    dst_stall_pct = 25;
    for (int f = 0; f < 40; f++)
      add_frame(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)), ($urandom_range(9) == 0), 3'($urandom_range(7)));
    run_until_idle(5000, "random");
    src_stall_pct = 0;
    dst_stall_pct = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    tx_dst_rdy_n = 1'b1;
    rx_data = '0; rx_drem = '0;
    rx_sof_n = '1; rx_eof_n = '1; rx_sop_n = '1; rx_eop_n = '1; rx_src_rdy_n = '1;
    test_reset();
    test_two_sources();
    test_round_robin();
    test_stall();
    test_frame_err();
    test_mid_reset();
    test_single_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fl_fifo_input_arbiter.md
# fl_fifo_input_arbiter

Frame-granular round-robin arbiter that shares the single FrameLink write port of the FrameLink FIFO between several FrameLink sources (hardware generator, software driver path, loopback). It grants one source at a time, passes that source's frame words unmodified into the FIFO, and releases only after the frame's last word is accepted, so frames from different sources never interleave.

## Interface
- DATA_WIDTH, 64, FrameLink data width in bits
- DREM_WIDTH, 3, log2(DATA_WIDTH/8)
- INPUTS, 4, number of requesting sources (2..8)

- CLK  in  1  clock
- RESET_N  in  1  asynchronous reset, active low
- RX_DATA  in  INPUTS*DATA_WIDTH  source data, input i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- RX_DREM  in  INPUTS*DREM_WIDTH  source drem, same packing
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  INPUTS each  source framing, active low
- RX_SRC_RDY_N  in  INPUTS  source valid, active low
- RX_DST_RDY_N  out  INPUTS  ready back to each source, active low
- TX_DATA  out  DATA_WIDTH  to FIFO write port
- TX_DREM  out  DREM_WIDTH  to FIFO
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  to FIFO
- TX_SRC_RDY_N  out  1  to FIFO, active low
- TX_DST_RDY_N  in  1  FIFO ready, active low
- GRANT  out  INPUTS  one-hot currently granted source, 0 when idle
- FRAME_ERR  out  1  one-cycle pulse: granted source presented a first word with SOF_N=1

## Operation
- States: IDLE, LOCK.
- IDLE: request vector req[i] = ~RX_SRC_RDY_N[i]. If any set, choose first set index searching from (last+1) mod INPUTS upward, wrapping; register GRANT, last <= index, go LOCK. No word transferred in IDLE.
- LOCK: TX_* = selected input's RX_* (combinational mux from registered grant); RX_DST_RDY_N[sel] = TX_DST_RDY_N; all other RX_DST_RDY_N = 1.
- Transfer = TX_SRC_RDY_N=0 and TX_DST_RDY_N=0. Transfer with TX_EOF_N=0 -> GRANT <= 0, go IDLE.
- first flag set on entering LOCK, cleared on first transfer. Transfer while first=1 and TX_SOF_N=1 -> FRAME_ERR pulse next cycle; frame still forwarded until EOF.
- Grant never changes mid-frame regardless of other requests or source stalls.
- Single-word frame (SOF_N=EOF_N=0): one transfer, return to IDLE.
- last resets to INPUTS-1, so input 0 wins the first arbitration.

## Timing
- Reset (async, RESET_N=0): state IDLE, GRANT=0, FRAME_ERR=0, last=INPUTS-1; TX_SRC_RDY_N=1, TX_SOF_N/EOF_N/SOP_N/EOP_N=1, TX_DATA=0, TX_DREM=0, all RX_DST_RDY_N=1.
- In IDLE all TX outputs hold reset values and all RX_DST_RDY_N=1.
- Arbitration latency: request seen in cycle n -> GRANT valid and first word may transfer in cycle n+1.
- Zero added data latency in LOCK (pure mux). One idle bubble between consecutive frames.
- After EOF transfer in cycle n, IDLE in n+1, next frame's first transfer earliest n+2.
- RESET_N asserted mid-frame: abort immediately, partial frame not completed; after release arbitration restarts from input 0.

## Configuration
- FL_ARB_PRIORITY_EN defined: arbitration in IDLE is strict priority, lowest index wins; last is unused.
- Not defined: round-robin as above.
- Lock, release, FRAME_ERR and timing identical in both builds.

## Test plan
- Reset then inputs 0 and 2 request 3-word frames simultaneously -> GRANT=0001 for 3 transfers, 1 idle cycle, GRANT=0100 for 3 transfers; no interleaving on TX.
- All 4 inputs request continuously with 1-word frames -> grant order 0,1,2,3,0 (round robin); with FL_ARB_PRIORITY_EN -> 0 every time.
- Granted frame of 5 words, TX_DST_RDY_N=1 for 4 cycles mid-frame, input 1 requesting -> GRANT stays, RX_DST_RDY_N[sel]=1 during stall, input 1 never sees ready until EOF.
- Input 3 first word with SOF_N=1 -> FRAME_ERR single-cycle pulse, frame forwarded to EOF, then IDLE.
- RESET_N low during word 2 of a 4-word frame from input 1 -> TX_SRC_RDY_N=1, GRANT=0 asynchronously; after release, input 0 and 1 requesting -> input 0 granted.
- Single-word frame (SOF_N=EOF_N=0, DREM=5) -> one transfer, TX_DREM=5, back to IDLE next cycle.
